// File: rtl/rv32i_fetch_pkg.sv
// rtl/rv32i_fetch_pkg.sv - shared constants and types for the instruction fetch front-end
package rv32i_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int F3_LSB     = 12;
  localparam int F3_MSB     = 14;
  localparam int F7_LSB     = 25;
  localparam int F7_MSB     = 31;

  localparam int PC_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO with flush; head is read straight from storage
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  // Flush wins over any same-cycle push or pop.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, credit-limited imem requests, response buffer and decode handoff
module instruction_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [6:0]        dec_opcode,
  output logic [2:0]        dec_f3,
  output logic [6:0]        dec_f7
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0]     drop_q;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     buf_count;
  logic              buf_empty;
  logic [ADDR_W-1:0] pcq_head;
  logic              pcq_empty;
  logic              req_fire;
  logic              rsp_keep;
  logic [CW:0]       credits_used;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc;

  // Credits count both in-flight requests and buffered words; a pop only frees one next cycle.
  assign credits_used   = (CW+1)'(inflight) + (CW+1)'(buf_count);
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0);

  assign push_entry = {PC_W'(pcq_head), imem_rsp_data};

  // Addresses of outstanding live requests, oldest first; its count is the in-flight total.
  fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .head      (pcq_head),
    .count     (inflight),
    .empty     (pcq_empty)
  );

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (dec_valid && dec_ready),
    .head      (head_entry),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (req_fire) begin
      pc_q <= pc_q + ADDR_W'(4);
    end
  end

  // A response landing in the redirect cycle is already stale, so it leaves the tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (redirect_valid) begin
      drop_q <= drop_q + inflight - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_q <= drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_instr <= NOP_INSTR;
      hold_pc    <= RESET_PC;
    end else if (!buf_empty) begin
      hold_instr <= head_entry.instr;
      hold_pc    <= ADDR_W'(head_entry.pc);
    end
  end

  assign dec_valid  = !buf_empty;
  assign dec_instr  = buf_empty ? hold_instr : head_entry.instr;
  assign dec_pc     = buf_empty ? hold_pc : ADDR_W'(head_entry.pc);
  assign dec_opcode = dec_instr[OPCODE_MSB:OPCODE_LSB];
  assign dec_f3     = dec_instr[F3_MSB:F3_LSB];
  assign dec_f7     = dec_instr[F7_MSB:F7_LSB];

  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((drop_q != '0) || !pcq_empty));

endmodule
